prio_arb_8ch: RTL and testbench

PRIO_ARB_8CH -- requirements
Module: prio_arb_8ch

---
 rtl/prio_arb_8ch.sv | 115 +++++++++++
 tb/tb_prio_arb_8ch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_arb_8ch.sv
// 8-requester arbiter with fixed-priority or round-robin selection, a hold-time
// limit per grant, and one mandatory idle cycle between consecutive grants.
//
// state | meaning
// IDLE  | no owner; arbitrate on any edge where req != 0
// GRANT | one owner holds gnt; release on done, owner drop, or hold limit
module prio_arb_8ch #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  input  logic       rr_en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state_q;
  logic [7:0]    gnt_q;
  logic [2:0]    gnt_id_q;
  logic          busy_q;
  logic          timeout_q;
  logic [HW-1:0] hcnt_q;
  logic [2:0]    last_q;

  logic [2:0]    base_d;
  logic [2:0]    idx_d;
  logic [2:0]    win_d;
  logic [HW-1:0] hcnt_d;
  logic          owner_req_d;
  logic          hold_hit_d;
  logic          release_d;
  logic          timeout_d;

  // Search descends from base-1 and wraps to base itself last; the smallest
  // step that hits a set request wins, so iterate from the far end down.
  // Fixed priority is the same search anchored at 0 (7 first, 0 last).
  always_comb begin
    base_d = rr_en ? last_q : 3'd0;
    idx_d  = 3'd0;
    win_d  = 3'd0;
    for (int i = 8; i >= 1; i--) begin
      idx_d = base_d - 3'(i);
      if (req[idx_d]) win_d = idx_d;
    end
  end

  always_comb begin
    owner_req_d = req[gnt_id_q];
    hold_hit_d  = (hcnt_q == HOLD_LAST);
    release_d   = done || !owner_req_d || hold_hit_d;
    timeout_d   = hold_hit_d && !done && owner_req_d;
    hcnt_d      = hcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 8'd0;
      gnt_id_q  <= 3'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hcnt_q    <= '0;
      last_q    <= 3'd0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q  <= GRANT;
            gnt_q    <= 8'd1 << win_d;
            gnt_id_q <= win_d;
            busy_q   <= 1'b1;
            hcnt_q   <= '0;
            last_q   <= win_d;
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q   <= IDLE;
            gnt_q     <= 8'd0;
            gnt_id_q  <= 3'd0;
            busy_q    <= 1'b0;
            hcnt_q    <= '0;
            timeout_q <= timeout_d;
          end else begin
            hcnt_q <= hcnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 8'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_prio_arb_8ch.sv
// Scoreboard bench for prio_arb_8ch: directed scenarios plus random traffic,
// checked every cycle against a transaction-level owner/age model.
module tb_prio_arb_8ch;
  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic       rr_en = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  prio_arb_8ch #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .rr_en(rr_en),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   checks = 0;
  int   failures = 0;
  logic prev_busy = 1'b0;

  int m_owner = -1;
  int m_age = 0;
  int m_last = 0;

  function automatic int pick(input logic [7:0] r, input logic rr);
    int base;
    int idx;
    base = rr ? m_last : 0;
    for (int k = 1; k <= 8; k++) begin
      idx = (base - k + 8) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_age = 0;
    m_last = 0;
  endfunction

  task automatic cycle(input logic [7:0] r, input logic d, input logic rr);
    exp_t e;
    bit hit;
    bit rel;
    @(negedge clk);
    req = r;
    done = d;
    rr_en = rr;
    e.to = 1'b0;
    if (m_owner >= 0) begin
      hit = (m_age == MH - 1);
      rel = d || !r[m_owner] || hit;
      if (rel) begin
        e.to = hit && !d && r[m_owner];
        m_owner = -1;
      end else begin
        m_age++;
      end
    end else if (r != 8'd0) begin
      m_owner = pick(r, rr);
      m_last = m_owner;
      m_age = 0;
    end
    e.busy = (m_owner >= 0);
    e.gnt  = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    e.id   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (busy && !prev_busy) grant_log.push_back(int'(gnt_id));
      prev_busy = busy;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (busy !== e.busy || gnt !== e.gnt || gnt_id !== e.id || timeout !== e.to) begin
          failures++;
          $display("FAIL sb t=%0t actual busy=%b gnt=%b id=%0d to=%b required busy=%b gnt=%b id=%0d to=%b",
                   $time, busy, gnt, gnt_id, timeout, e.busy, e.gnt, e.id, e.to);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if (gnt !== 8'd0 || gnt_id !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL %s actual gnt=%b id=%0d busy=%b to=%b required all zero",
               name, gnt, gnt_id, busy, timeout);
    end
  endtask

  task automatic check_log(input string name, input int exp_ids[$]);
    checks++;
    if (grant_log.size() != exp_ids.size()) begin
      failures++;
      $display("FAIL %s actual grants=%0d required grants=%0d", name, grant_log.size(), exp_ids.size());
    end else begin
      foreach (exp_ids[i]) begin
        if (grant_log[i] != exp_ids[i]) begin
          failures++;
          $display("FAIL %s actual grant[%0d]=%0d required %0d", name, i, grant_log[i], exp_ids[i]);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'd0;
    done = 1'b0;
    rr_en = 1'b0;
    @(negedge clk);
    sb_q.delete();
    model_reset();
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    grant_log.delete();
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] r;
    logic rr;

    // fixed priority, done on third grant cycle
    do_reset();
    for (int i = 0; i < 10; i++) cycle(8'b11001100, (m_owner >= 0 && m_age == 2), 1'b0);
    settle();
    check_log("fixed_prio", '{7, 7, 7});

    // round robin, done on second grant cycle
    do_reset();
    for (int i = 0; i < 10; i++) cycle(8'b10010010, (m_owner >= 0 && m_age == 1), 1'b1);
    settle();
    check_log("round_robin", '{7, 4, 1, 7});

    // hold-limit timeout, then done colliding with the limit
    do_reset();
    for (int i = 0; i < 40; i++) cycle(8'b00000001, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(8'b00000001, (m_owner >= 0 && m_age == MH - 1), 1'b0);
    settle();
    check_log("timeout_regrant", '{0, 0, 0, 0, 0});

    // owner drops its request while a higher requester waits
    do_reset();
    for (int i = 0; i < 3; i++) cycle(8'b00100000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(8'b01100000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(8'b01000000, 1'b0, 1'b0);
    settle();
    check_log("req_drop", '{5, 6});

    // asynchronous reset between edges during a grant
    do_reset();
    for (int i = 0; i < 3; i++) cycle(8'hFF, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    sb_q.delete();
    model_reset();
    @(negedge clk);
    req = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    grant_log.delete();
    for (int i = 0; i < 3; i++) cycle(8'b00000011, 1'b0, 1'b1);
    settle();
    check_log("post_reset_rr", '{1});

    // random traffic
    do_reset();
    r = 8'($urandom);
    rr = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) r = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) rr = ~rr;
      cycle(r, ($urandom_range(0, 19) == 0), rr);
    end
    settle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
